// File: rtl/cluster_chunk_sched.sv
// cluster_chunk_sched: ping-pong chunk loader/compute sequencer with per-tile unit drain; SCHED_PERF_CNT_EN adds perf counters.
// Compute starts 1 cycle after a bank fills; source ready drops while both banks are full; drain holds on out_ready_i.
module cluster_chunk_sched #(
  parameter int CU_NUM      = 8,
  parameter int WR_CYC      = 4,
  parameter int OUT_BUF_NUM = 2,
  parameter int CNT_W       = 16,
  localparam int WC_W = (WR_CYC > 1) ? $clog2(WR_CYC) : 1,
  localparam int CU_W = (CU_NUM > 1) ? $clog2(CU_NUM) : 1,
  localparam int AB_W = (OUT_BUF_NUM > 1) ? $clog2(OUT_BUF_NUM) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CNT_W-1:0]  cfg_chunk_num_i,
  input  logic              ifm_src_valid_i,
  output logic              ifm_src_ready_o,
  input  logic              fil_src_valid_i,
  output logic              fil_src_ready_o,
  output logic              ifm_chunk_wr_valid_o,
  output logic              fil_chunk_wr_valid_o,
  output logic [WC_W-1:0]   ifm_chunk_wr_count_o,
  output logic [WC_W-1:0]   fil_chunk_wr_count_o,
  output logic              ifm_chunk_wr_sel_o,
  output logic              fil_chunk_wr_sel_o,
  output logic              ifm_chunk_rd_sel_o,
  output logic              fil_chunk_rd_sel_o,
  output logic [CU_NUM-1:0] fil_chunk_cu_wr_sel_o,
  output logic              run_valid_o,
  output logic              total_chunk_start_o,
  input  logic              total_chunk_end_i,
  output logic [AB_W-1:0]   acc_buf_sel_o,
  output logic [CU_W-1:0]   com_unit_out_buf_sel_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              done_o,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_busy_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} top_st_t;
  typedef enum logic {C_IDLE, C_BUSY} cmp_st_t;

  top_st_t st, st_nxt;
  cmp_st_t cst, cst_nxt;

  logic [CNT_W-1:0] chunk_num, ld_cnt, cmp_cnt;
  logic [1:0]       full, full_set, full_clr;
  logic             wr_bank, rd_bank, fil_phase;
  logic [WC_W-1:0]  beat;
  logic [CU_W-1:0]  unit, drn;
  logic [AB_W-1:0]  acc;
  logic             cfg_hs, ld_en, ifm_hs, fil_hs, beat_last, unit_last, ld_done;
  logic             c_start, c_end, drn_hs, drn_last;

  assign cfg_hs    = (st == S_IDLE) && cfg_valid_i;
  assign ld_en     = (st == S_RUN) && (ld_cnt < chunk_num) && !full[wr_bank];
  assign ifm_hs    = ld_en && !fil_phase && ifm_src_valid_i;
  assign fil_hs    = ld_en && fil_phase && fil_src_valid_i;
  assign beat_last = (beat == WC_W'(WR_CYC - 1));
  assign unit_last = (unit == CU_W'(CU_NUM - 1));
  assign ld_done   = fil_hs && beat_last && unit_last;
  assign c_start   = (st == S_RUN) && (cst == C_IDLE) && full[rd_bank];
  // cst is still C_IDLE in the launch cycle, so an end there is ignored
  assign c_end     = (cst == C_BUSY) && total_chunk_end_i;
  assign drn_last  = (drn == CU_W'(CU_NUM - 1));
  assign drn_hs    = (st == S_DRAIN) && out_ready_i;
  assign full_set  = {ld_done && wr_bank, ld_done && !wr_bank};
  assign full_clr  = {c_end && rd_bank, c_end && !rd_bank};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st  <= S_IDLE;
      cst <= C_IDLE;
    end else begin
      st  <= st_nxt;
      cst <= cst_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    cst_nxt = cst;
    case (st)
      S_IDLE:  if (cfg_valid_i) st_nxt = S_RUN;
      S_RUN:   if (cmp_cnt == chunk_num) st_nxt = S_DRAIN;
      S_DRAIN: if (drn_hs && drn_last) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
    if (c_start) cst_nxt = C_BUSY;
    else if (c_end) cst_nxt = C_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      chunk_num <= '0;
      ld_cnt    <= '0;
      cmp_cnt   <= '0;
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      fil_phase <= 1'b0;
      beat      <= '0;
      unit      <= '0;
      drn       <= '0;
      acc       <= '0;
    end else begin
      if (cfg_hs) begin
        chunk_num <= (cfg_chunk_num_i == '0) ? CNT_W'(1) : cfg_chunk_num_i;
        ld_cnt    <= '0;
        cmp_cnt   <= '0;
        fil_phase <= 1'b0;
        beat      <= '0;
        unit      <= '0;
      end
      if (ifm_hs || fil_hs) beat <= beat_last ? '0 : beat + WC_W'(1);
      if (ifm_hs && beat_last) fil_phase <= 1'b1;
      if (fil_hs && beat_last) begin
        unit <= unit_last ? '0 : unit + CU_W'(1);
        if (unit_last) fil_phase <= 1'b0;
      end
      if (ld_done) begin
        wr_bank <= !wr_bank;
        ld_cnt  <= ld_cnt + CNT_W'(1);
      end
      if (c_end) begin
        rd_bank <= !rd_bank;
        cmp_cnt <= cmp_cnt + CNT_W'(1);
      end
      // set and clear always hit opposite banks, so both apply
      full <= (full | full_set) & ~full_clr;
      if (drn_hs) drn <= drn_last ? '0 : drn + CU_W'(1);
      if (drn_hs && drn_last)
        acc <= (acc == AB_W'(OUT_BUF_NUM - 1)) ? '0 : acc + AB_W'(1);
    end
  end

  always_comb begin
    cfg_ready_o            = (st == S_IDLE);
    ifm_src_ready_o        = ld_en && !fil_phase;
    fil_src_ready_o        = ld_en && fil_phase;
    ifm_chunk_wr_valid_o   = ifm_hs;
    fil_chunk_wr_valid_o   = fil_hs;
    ifm_chunk_wr_count_o   = fil_phase ? '0 : beat;
    fil_chunk_wr_count_o   = fil_phase ? beat : '0;
    ifm_chunk_wr_sel_o     = wr_bank;
    fil_chunk_wr_sel_o     = wr_bank;
    ifm_chunk_rd_sel_o     = rd_bank;
    fil_chunk_rd_sel_o     = rd_bank;
    fil_chunk_cu_wr_sel_o  = (ld_en && fil_phase) ? (CU_NUM'(1) << unit) : '0;
    run_valid_o            = c_start || (cst == C_BUSY);
    total_chunk_start_o    = c_start;
    acc_buf_sel_o          = acc;
    com_unit_out_buf_sel_o = drn;
    out_valid_o            = (st == S_DRAIN);
    out_last_o             = (st == S_DRAIN) && drn_last;
    done_o                 = drn_hs && drn_last;
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] busy_cnt, stall_cnt;
  logic        starve;

  // starved: running a tile with work left but nothing computing or launching
  assign starve = (st == S_RUN) && (cst == C_IDLE) && !c_start && (cmp_cnt < chunk_num);

  always_ff @(posedge clk_i) begin
    if (!rst_i || cfg_hs) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (run_valid_o && (busy_cnt != '1)) busy_cnt <= busy_cnt + 32'd1;
      if (starve && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_busy_cnt_o  = busy_cnt;
  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_busy_cnt_o  = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cluster_chunk_sched.sv
// Randomized bench for cluster_chunk_sched against a tile/chunk-level reference model.
module tb_cluster_chunk_sched;
  localparam int CU  = 4;
  localparam int WR  = 4;
  localparam int OB  = 2;
  localparam int CW  = 16;
  localparam int BPC = WR * (1 + CU);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_valid_i, cfg_ready_o;
  logic [CW-1:0] cfg_chunk_num_i;
  logic          ifm_src_valid_i, ifm_src_ready_o, fil_src_valid_i, fil_src_ready_o;
  logic          ifm_chunk_wr_valid_o, fil_chunk_wr_valid_o;
  logic [1:0]    ifm_chunk_wr_count_o, fil_chunk_wr_count_o;
  logic          ifm_chunk_wr_sel_o, fil_chunk_wr_sel_o, ifm_chunk_rd_sel_o, fil_chunk_rd_sel_o;
  logic [CU-1:0] fil_chunk_cu_wr_sel_o;
  logic          run_valid_o, total_chunk_start_o, total_chunk_end_i;
  logic          acc_buf_sel_o;
  logic [1:0]    com_unit_out_buf_sel_o;
  logic          out_valid_o, out_ready_i, out_last_o, done_o;
  logic [31:0]   perf_stall_cnt_o, perf_busy_cnt_o;

  cluster_chunk_sched #(.CU_NUM(CU), .WR_CYC(WR), .OUT_BUF_NUM(OB), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_chunk_num_i(cfg_chunk_num_i),
    .ifm_src_valid_i(ifm_src_valid_i), .ifm_src_ready_o(ifm_src_ready_o),
    .fil_src_valid_i(fil_src_valid_i), .fil_src_ready_o(fil_src_ready_o),
    .ifm_chunk_wr_valid_o(ifm_chunk_wr_valid_o), .fil_chunk_wr_valid_o(fil_chunk_wr_valid_o),
    .ifm_chunk_wr_count_o(ifm_chunk_wr_count_o), .fil_chunk_wr_count_o(fil_chunk_wr_count_o),
    .ifm_chunk_wr_sel_o(ifm_chunk_wr_sel_o), .fil_chunk_wr_sel_o(fil_chunk_wr_sel_o),
    .ifm_chunk_rd_sel_o(ifm_chunk_rd_sel_o), .fil_chunk_rd_sel_o(fil_chunk_rd_sel_o),
    .fil_chunk_cu_wr_sel_o(fil_chunk_cu_wr_sel_o),
    .run_valid_o(run_valid_o), .total_chunk_start_o(total_chunk_start_o),
    .total_chunk_end_i(total_chunk_end_i),
    .acc_buf_sel_o(acc_buf_sel_o), .com_unit_out_buf_sel_o(com_unit_out_buf_sel_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o),
    .done_o(done_o), .perf_stall_cnt_o(perf_stall_cnt_o), .perf_busy_cnt_o(perf_busy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: tile phase (0 idle, 1 run, 2 drain) plus chunk/beat totals
  int m_st, m_n, ld_t, cmp_t, busy, g_ld, g_cmp, beat, drn, acc;
  int m_busy_cnt, m_stall_cnt, end_at, tiles_done;
  int cfg_req, cfg_n, rst_arm;
  int ifm_pct, fil_pct, ord_pct, dlo, dhi, spur_pct;
  int obs_starts, obs_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_n = 1; ld_t = 0; cmp_t = 0; busy = 0; g_ld = 0; g_cmp = 0;
    beat = 0; drn = 0; acc = 0; m_busy_cnt = 0; m_stall_cnt = 0; end_at = -1;
    cfg_req = 0;
  endtask

  task automatic step();
    logic e_load, e_ifm_rdy, e_fil_rdy, e_start, e_drain, ifm_hs, fil_hs, cfg_hs;
    logic do_rst;
    int   unit, cmp_before;
    @(negedge clk_i);
    e_load    = (m_st == 1) && (ld_t < m_n) && (ld_t - cmp_t < 2);
    e_ifm_rdy = e_load && (beat < WR);
    e_fil_rdy = e_load && (beat >= WR);
    e_start   = (m_st == 1) && (busy == 0) && (ld_t > cmp_t);
    e_drain   = (m_st == 2);
    do_rst    = (rst_arm != 0) && (m_st == 1) && (beat == WR + 7);
    if (do_rst) rst_arm = 0;
    rst_i             = !do_rst;
    cfg_valid_i       = (cfg_req != 0);
    cfg_chunk_num_i   = (cfg_req != 0) ? CW'(cfg_n) : CW'($urandom);
    ifm_src_valid_i   = ($urandom_range(99) < ifm_pct);
    fil_src_valid_i   = ($urandom_range(99) < fil_pct);
    out_ready_i       = ($urandom_range(99) < ord_pct);
    total_chunk_end_i = (busy != 0) ? (cyc == end_at) : ($urandom_range(99) < spur_pct);
    #1;
    if (do_rst) begin
      model_reset();
    end else begin
      ifm_hs = e_ifm_rdy && ifm_src_valid_i;
      fil_hs = e_fil_rdy && fil_src_valid_i;
      cfg_hs = (m_st == 0) && cfg_valid_i;
      check_val("cfg_rdy", 32'(cfg_ready_o), 32'(m_st == 0));
      check_val("ifm_rdy", 32'(ifm_src_ready_o), 32'(e_ifm_rdy));
      check_val("fil_rdy", 32'(fil_src_ready_o), 32'(e_fil_rdy));
      check_val("ifm_wv", 32'(ifm_chunk_wr_valid_o), 32'(ifm_hs));
      check_val("fil_wv", 32'(fil_chunk_wr_valid_o), 32'(fil_hs));
      check_val("ifm_wsel", 32'(ifm_chunk_wr_sel_o), g_ld % 2);
      check_val("fil_wsel", 32'(fil_chunk_wr_sel_o), g_ld % 2);
      check_val("ifm_rsel", 32'(ifm_chunk_rd_sel_o), g_cmp % 2);
      check_val("fil_rsel", 32'(fil_chunk_rd_sel_o), g_cmp % 2);
      if (ifm_hs) check_val("ifm_cnt", 32'(ifm_chunk_wr_count_o), beat);
      if (fil_hs) begin
        unit = (beat - WR) / WR;
        check_val("fil_cnt", 32'(fil_chunk_wr_count_o), (beat - WR) % WR);
        check_val("cu_sel", 32'(fil_chunk_cu_wr_sel_o), 1 << unit);
      end
      if (!((m_st == 1) && (beat >= WR)))
        check_val("cu_sel_idle", 32'(fil_chunk_cu_wr_sel_o), 0);
      check_val("start", 32'(total_chunk_start_o), 32'(e_start));
      check_val("run_v", 32'(run_valid_o), 32'(e_start || (busy != 0)));
      check_val("out_v", 32'(out_valid_o), 32'(e_drain));
      check_val("out_sel", 32'(com_unit_out_buf_sel_o), drn);
      check_val("out_last", 32'(out_last_o), 32'(e_drain && (drn == CU - 1)));
      check_val("done", 32'(done_o), 32'(e_drain && out_ready_i && (drn == CU - 1)));
      check_val("acc_sel", 32'(acc_buf_sel_o), acc);
`ifdef SCHED_PERF_CNT_EN
      check_val("perf_busy", perf_busy_cnt_o, 32'(m_busy_cnt));
      check_val("perf_stall", perf_stall_cnt_o, 32'(m_stall_cnt));
`else
      check_val("perf_busy0", perf_busy_cnt_o, 0);
      check_val("perf_stall0", perf_stall_cnt_o, 0);
`endif
      obs_starts += int'(total_chunk_start_o);
      obs_done   += int'(done_o);

      // model update from the stimulus the bench applied this cycle
      cmp_before = cmp_t;
      if (!cfg_hs) begin
        m_busy_cnt  += int'(e_start || (busy != 0));
        m_stall_cnt += int'((m_st == 1) && (busy == 0) && !e_start && (cmp_t < m_n));
      end
      if (cfg_hs) begin
        m_n = (cfg_n == 0) ? 1 : cfg_n;
        ld_t = 0; cmp_t = 0; m_st = 1; cfg_req = 0;
        m_busy_cnt = 0; m_stall_cnt = 0;
      end else if (m_st == 1) begin
        if (ifm_hs || fil_hs) begin
          beat++;
          if (beat == BPC) begin beat = 0; ld_t++; g_ld++; end
        end
        if ((busy != 0) && total_chunk_end_i) begin
          busy = 0; cmp_t++; g_cmp++;
        end else if (e_start) begin
          busy = 1;
          end_at = cyc + int'($urandom_range(dhi, dlo));
        end
        if (cmp_before == m_n) m_st = 2;
      end else if (m_st == 2) begin
        if (out_ready_i) begin
          if (drn == CU - 1) begin
            drn = 0; acc = (acc + 1) % OB; m_st = 0; tiles_done++;
          end else drn++;
        end
      end
    end
    cyc++;
  endtask

  task automatic run_tile(input int n, input int ip, input int fp, input int op,
                          input int dl, input int dh, input int sp, input int with_rst);
    int start_tiles, guard;
    logic fin;
    start_tiles = tiles_done;
    cfg_n = n; cfg_req = 1; rst_arm = with_rst;
    ifm_pct = ip; fil_pct = fp; ord_pct = op; dlo = dl; dhi = dh; spur_pct = sp;
    obs_starts = 0; obs_done = 0;
    fin = 1'b0;
    for (guard = 0; guard < 8000 && !fin; guard++) begin
      step();
      fin = (tiles_done != start_tiles) || ((with_rst != 0) && (rst_arm == 0) && (m_st == 0));
    end
    check_val("tile_fin", 32'(fin), 1);
    check_val("tile_starts", 32'(obs_starts), (with_rst != 0) ? 0 : ((n == 0) ? 1 : n));
    check_val("tile_done_cnt", 32'(obs_done), (with_rst != 0) ? 0 : 1);
    ifm_pct = 100; fil_pct = 100; spur_pct = 0;
    repeat (3) step();
  endtask

  initial begin
    rst_i = 1'b0; cfg_valid_i = 1'b0; cfg_chunk_num_i = '0;
    ifm_src_valid_i = 1'b0; fil_src_valid_i = 1'b0; out_ready_i = 1'b0;
    total_chunk_end_i = 1'b0;
    model_reset();
    tiles_done = 0; rst_arm = 0; obs_starts = 0; obs_done = 0;
    ifm_pct = 100; fil_pct = 100; ord_pct = 100; dlo = 1; dhi = 1; spur_pct = 0; cfg_n = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_val("rst_cfg_rdy", 32'(cfg_ready_o), 1);
    check_val("rst_run_v", 32'(run_valid_o), 0);
    check_val("rst_out_v", 32'(out_valid_o), 0);
    check_val("rst_acc", 32'(acc_buf_sel_o), 0);
    check_val("rst_wsel", 32'(ifm_chunk_wr_sel_o), 0);
    repeat (2) step();

    run_tile(1, 100, 100, 100, 5, 5, 0, 0);
    check_val("acc_after_single", 32'(acc_buf_sel_o), 1);
    run_tile(3, 100, 100, 100, 40, 40, 0, 0);
    run_tile(4, 100, 100, 100, 100, 100, 0, 0);
    run_tile(5, 50, 50, 30, 1, 30, 50, 0);
    run_tile(0, 100, 100, 100, 1, 3, 20, 0);
    run_tile(3, 100, 100, 100, 20, 20, 0, 1);
    check_val("post_rst_acc", 32'(acc_buf_sel_o), 0);
    check_val("post_rst_wsel", 32'(fil_chunk_wr_sel_o), 0);
    run_tile(2, 100, 100, 100, 10, 10, 0, 0);
`ifdef SCHED_PERF_CNT_EN
    check_val("perf_busy_22", perf_busy_cnt_o, 22);
    check_val("perf_stall_end", perf_stall_cnt_o, 32'(m_stall_cnt));
`endif
    for (int t = 0; t < 3; t++)
      run_tile(int'($urandom_range(6, 1)), 60, 70, 50, 1, 25, 30, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
